// File: rtl/loader_pkg.sv
// Shared types for the UART-driven instruction memory loader.
// State encoding and status byte values.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE
  } state_t;

  localparam logic [7:0] ACK_OK   = 8'h4B;
  localparam logic [7:0] ACK_ERR  = 8'h45;
  localparam logic [7:0] SYNC_DEF = 8'hA5;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian byte-lane assembler with a one-byte skid register.
// The skid catches a byte that lands while the word is being written.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        take_en,
  input  logic        hold_en,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  byte_idx;
  logic [23:0] lanes;
  logic        skid_v;
  logic [7:0]  skid_d;
  logic        take;
  logic [7:0]  cur;

  assign take       = take_en && (skid_v || rx_valid);
  assign cur        = skid_v ? skid_d : rx_data;
  assign word_ready = take && (byte_idx == 2'd3);
  assign word       = {cur, lanes};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= '0;
      lanes    <= '0;
      skid_v   <= 1'b0;
      skid_d   <= '0;
    end else if (clr) begin
      byte_idx <= '0;
      skid_v   <= 1'b0;
    end else if (take) begin
      byte_idx <= byte_idx + 2'd1;
      unique case (byte_idx)
        2'd0:    lanes[7:0]   <= cur;
        2'd1:    lanes[15:8]  <= cur;
        2'd2:    lanes[23:16] <= cur;
        default: ;
      endcase
      // a skid drain with a fresh byte arriving refills the skid
      skid_v <= skid_v && rx_valid;
      if (rx_valid)
        skid_d <= rx_data;
    end else if (hold_en && rx_valid) begin
      skid_v <= 1'b1;
      skid_d <= rx_data;
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Loads imem from a framed UART byte stream while holding the core in reset.
// Frame: SYNC, len_lo, len_hi, then len little-endian 32-bit words.
module imem_uart_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 5,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEF,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        load_req,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [31:0] imem_din,
  output logic [31:0] imem_addr,
  output logic        imem_web,
  output logic        core_rst,
  output logic        load_done,
  output logic        load_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

  state_t        state;
  logic [15:0]   cnt;
  logic [15:0]   word_idx;
  logic [TW-1:0] idle_cnt;
  logic          sent;
  logic          active;
  logic          abort;
  logic          clr;
  logic [31:0]   word;
  logic          word_ready;

  assign active = (state == LEN_LO) || (state == LEN_HI) ||
                  (state == DATA);
  assign abort  = load_req && (state != IDLE);
  assign clr    = abort || !((state == DATA) || (state == WRITE));

  loader_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .take_en    ((state == DATA) && !abort),
    .hold_en    ((state == WRITE) && !abort),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      word_idx  <= '0;
      idle_cnt  <= '0;
      sent      <= 1'b0;
      imem_web  <= 1'b1;
      imem_addr <= '0;
      imem_din  <= '0;
      core_rst  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_start <= 1'b0;
      imem_web <= 1'b1;
      idle_cnt <= (active && !rx_valid) ? idle_cnt + TW'(1) : '0;
      if (abort) begin
        state     <= IDLE;
        core_rst  <= 1'b1;
        load_done <= 1'b0;
      end else if (active && !rx_valid && !word_ready &&
                   idle_cnt == TO_LAST) begin
        state    <= IDLE;
        load_err <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
              state    <= LEN_LO;
              load_err <= 1'b0;
            end
          end
          LEN_LO: begin
            if (rx_valid) begin
              cnt[7:0] <= rx_data;
              state    <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (rx_valid) begin
              cnt[15:8] <= rx_data;
              word_idx  <= '0;
              if ({rx_data, cnt[7:0]} == 16'd0) begin
                state     <= DONE;
                core_rst  <= 1'b0;
                load_done <= 1'b1;
                sent      <= 1'b0;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (word_ready) begin
              state     <= WRITE;
              imem_din  <= word;
              imem_addr <= {14'd0, word_idx, 2'b00};
              // words past the end of imem are consumed but dropped
              if ({1'b0, word_idx} < DEPTH)
                imem_web <= 1'b0;
              else
                load_err <= 1'b1;
            end
          end
          WRITE: begin
            word_idx <= word_idx + 16'd1;
            if (word_idx + 16'd1 == cnt) begin
              state     <= DONE;
              core_rst  <= 1'b0;
              load_done <= 1'b1;
              sent      <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
          DONE: begin
            if (!sent && !tx_busy) begin
              tx_start <= 1'b1;
              tx_data  <= load_err ? ACK_ERR : ACK_OK;
              sent     <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Writer side of the instruction-memory write port in Fetch: drives imem_din, imem_addr and imem_web from a byte stream delivered by the UART receiver.
- Holds the core in reset while loading, frames and assembles little-endian 32-bit words, and issues one-cycle write strobes.
- Releases the core once the programme is loaded, then sends a one-byte status back through the UART transmitter.

Parameters:
- ADDR_WIDTH, 5, word-address width of imem; depth DEPTH = 2**ADDR_WIDTH words.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle pulse; rx_data is valid in that cycle
- load_req  in  1  level/pulse request to (re)enter load mode
- tx_busy  in  1  UART transmitter busy
- tx_data  out  8  status byte to transmitter
- tx_start  out  1  one-cycle start pulse to transmitter
- imem_din  out  32  write data to imem
- imem_addr  out  32  byte address to imem (Fetch shifts right by 2)
- imem_web  out  1  imem write enable, active-low; 1 = core fetch owns the port
- core_rst  out  1  active-high reset to the pipeline
- load_done  out  1  high in DONE
- load_err  out  1  sticky error flag; cleared on entry to LEN_LO

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; imem_web=1; imem_addr=0; imem_din=0.
  - core_rst=1; load_done=0; load_err=0; tx_start=0; tx_data=0.
  - All counters = 0.
- State machine:
  - IDLE: core_rst=1. rx_valid with rx_data==SYNC_BYTE -> LEN_LO. Any other byte is ignored.
  - LEN_LO: byte -> cnt[7:0] -> LEN_HI.
  - LEN_HI: byte -> cnt[15:8].
    - If the resulting cnt==0 -> DONE.
    - Otherwise -> DATA with byte_idx=0, word_idx=0.
  - DATA: each rx_valid stores the byte into lane byte_idx (byte 0 -> [7:0], little-endian) and increments byte_idx. On the 4th byte -> WRITE.
  - WRITE: lasts exactly one cycle.
    - imem_web=0, imem_din = assembled word, imem_addr = word_idx<<2.
    - If word_idx >= DEPTH: keep imem_web=1, set load_err, and the bytes are still consumed.
    - Then word_idx+1. If word_idx+1==cnt -> DONE, else -> DATA.
  - DONE: core_rst=0, load_done=1.
    - On entry, once tx_busy=0, pulse tx_start for one cycle with tx_data = 8'h4B ('K') if !load_err, else 8'h45 ('E').
    - At most one status byte per frame.
- Outputs and timing:
  - imem_web, imem_addr and imem_din are registered on posedge. They are stable across the following negedge, where imem samples.
  - imem_addr holds its last value outside WRITE.
  - An rx_valid arriving during WRITE is held in a 1-byte skid register and consumed in the next DATA cycle. No byte is ever dropped.
- Timeout:
  - In LEN_LO, LEN_HI and DATA, the idle counter resets on every rx_valid.
  - On reaching TIMEOUT_CYCLES -> IDLE with load_err=1.
  - core_rst stays 1 and no status byte is sent.
- load_req:
  - From any state except IDLE -> IDLE next cycle; core_rst=1; partial word discarded.
  - load_req has priority over a simultaneous rx_valid.
- Mid-operation rst: asynchronous return to the reset values, and any in-flight write strobe is cancelled immediately.
- Power-on: after reset the core is held in reset until the first successful load.

Decomposition:
- Shared package loader_pkg:
  - state enum {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE}
  - ACK_OK=8'h4B, ACK_ERR=8'h45, default SYNC_BYTE.
- Sub-module loader_word_asm: byte-lane assembler plus byte_idx counter and skid register. Outputs word and word_ready.
- The FSM, counters, timeout and status transmit live in the top.

Test Plan:
- Load 2 words: bytes A5,02,00,13,05,A0,00,93,00,10,00 -> writes 0x00A00513@addr 0 and 0x00100093@addr 4; each write has imem_web=0 for exactly 1 cycle; then core_rst=0, load_done=1, tx_data=0x4B with a single tx_start.
- Zero length: A5,00,00 -> DONE directly, no imem_web low, status 0x4B.
- Overflow: ADDR_WIDTH=5 with count 33 -> 32 writes (addr 0..0x7C), 33rd word not written, load_err=1, status 0x45.
- Timeout: TIMEOUT_CYCLES=100; A5,01,00,11 then silence -> IDLE at cycle 100, load_err=1, core_rst=1, no tx_start.
- load_req asserted mid-DATA in the same cycle as rx_valid -> IDLE next cycle, byte ignored; a full re-sent frame then loads correctly.
- rst pulsed low during WRITE -> imem_web=1 immediately (asynchronous); all outputs at reset values.
